// File: rtl/mano_io_pkg.sv
// Shared constants for the Mano multi-channel I/O and interrupt unit:
// interrupt FSM encodings, flag reset values and arbitration modes.
package mano_io_pkg;

    typedef enum logic [0:0] {
        IRQ_IDLE = 1'b0,
        IRQ_ACK  = 1'b1
    } irq_state_e;

    // Plain constants mirror the enum so legacy code can use raw encodings
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACK  = 1'b1;

    localparam logic FGI_RST = 1'b0;
    localparam logic FGO_RST = 1'b1;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

endpackage

// File: rtl/mano_io_intr_if.sv
// Control-path strobes and device handshakes of the Mano I/O unit.
// The slave modport is the unit itself; master is the core/device side.
interface mano_io_intr_if #(
    parameter int DATA_W = 8,
    parameter int NCH    = 4,
    parameter int CH_W   = $clog2(NCH)
);
    logic [NCH-1:0]        dev_in_valid;
    logic [NCH*DATA_W-1:0] dev_in_data;
    logic [NCH-1:0]        dev_in_ready;
    logic [NCH-1:0]        dev_out_valid;
    logic [NCH*DATA_W-1:0] dev_out_data;
    logic [NCH-1:0]        dev_out_ready;
    logic [CH_W-1:0]       cs_ch_sel;
    logic                  cs_inp;
    logic                  cs_out;
    logic [DATA_W-1:0]     cs_out_data;
    logic                  cs_msk_ld;
    logic                  cs_ion;
    logic                  cs_iof;
    logic                  cs_t0;
    logic                  cs_r_clr;
    logic [DATA_W-1:0]     inp_data;
    logic                  fgi_sel;
    logic                  fgo_sel;
    logic                  r_flag;
    logic                  ien_flag;
    logic [CH_W-1:0]       int_vec;
    logic                  out_ovr;

    modport master (
        output dev_in_valid, dev_in_data, dev_out_ready, cs_ch_sel, cs_inp,
               cs_out, cs_out_data, cs_msk_ld, cs_ion, cs_iof, cs_t0, cs_r_clr,
        input  dev_in_ready, dev_out_valid, dev_out_data, inp_data, fgi_sel,
               fgo_sel, r_flag, ien_flag, int_vec, out_ovr
    );

    modport slave (
        input  dev_in_valid, dev_in_data, dev_out_ready, cs_ch_sel, cs_inp,
               cs_out, cs_out_data, cs_msk_ld, cs_ion, cs_iof, cs_t0, cs_r_clr,
        output dev_in_ready, dev_out_valid, dev_out_data, inp_data, fgi_sel,
               fgo_sel, r_flag, ien_flag, int_vec, out_ovr
    );
endinterface

// File: rtl/mano_io_arb.sv
// Priority arbiter: lowest pending index (fixed) or search starting one
// past the previous grant with wrap-around (round-robin).
module mano_io_arb
    import mano_io_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int CH_W = $clog2(NCH),
    parameter int RR   = ARB_FIXED
) (
    input  logic [NCH-1:0]  req,
    input  logic [CH_W-1:0] last_grant,
    output logic [CH_W-1:0] grant,
    output logic            any
);
    localparam int unsigned NCH_U = NCH;

    assign any = |req;

    always_comb begin
        logic        found;
        int unsigned idx;
        found = 1'b0;
        idx   = 0;
        grant = '0;
        for (int i = 0; i < NCH; i++) begin
            if (RR == ARB_RR)
                idx = (32'(last_grant) + 32'(i) + 32'd1) % NCH_U;
            else
                idx = 32'(i);
            if (!found && req[idx[CH_W-1:0]]) begin
                found = 1'b1;
                grant = idx[CH_W-1:0];
            end
        end
    end
endmodule

// File: rtl/mano_io_intr.sv
// NCH-channel generalisation of the Mano INPR/OUTR/FGI/FGO/IEN/R path:
// per-channel buffers and flags, interrupt mask, and an R-flag FSM.
module mano_io_intr
    import mano_io_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NCH    = 4,
    parameter int CH_W   = $clog2(NCH),
    parameter int RR     = ARB_FIXED
) (
    input logic          mclk,
    input logic          mrst,
    mano_io_intr_if.slave bus
);
    logic [DATA_W-1:0] inpr_reg [NCH];
    logic [DATA_W-1:0] outr_reg [NCH];
    logic [NCH-1:0]    fgi_reg;
    logic [NCH-1:0]    fgo_reg;
    logic [NCH-1:0]    msk_reg;
    logic              ien_reg;
    logic [0:0]        state_reg;
    logic [CH_W-1:0]   int_vec_reg;
    logic [CH_W-1:0]   last_grant_reg;
    logic              out_ovr_reg;

    logic              sel_ok;
    logic [NCH-1:0]    pend;
    logic [CH_W-1:0]   grant;
    logic              any_pend;

    // Channel selects beyond NCH address nothing (only reachable for non-power-of-2 NCH)
    assign sel_ok = (32'(bus.cs_ch_sel) < NCH);

    assign pend          = msk_reg & (fgi_reg | fgo_reg);
    assign bus.dev_in_ready  = ~fgi_reg;
    assign bus.dev_out_valid = ~fgo_reg;
    assign bus.inp_data  = sel_ok ? inpr_reg[bus.cs_ch_sel] : '0;
    assign bus.fgi_sel   = sel_ok & fgi_reg[bus.cs_ch_sel];
    assign bus.fgo_sel   = sel_ok & fgo_reg[bus.cs_ch_sel];
    assign bus.r_flag    = (state_reg == ST_ACK);
    assign bus.ien_flag  = ien_reg;
    assign bus.int_vec   = int_vec_reg;
    assign bus.out_ovr   = out_ovr_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic hit;
            assign hit = sel_ok && (bus.cs_ch_sel == CH_W'(gi));
            assign bus.dev_out_data[gi*DATA_W +: DATA_W] = outr_reg[gi];

            always_ff @(posedge mclk) begin
                if (mrst) begin
                    inpr_reg[gi] <= '0;
                    fgi_reg[gi]  <= FGI_RST;
                end else if (bus.dev_in_valid[gi] && !fgi_reg[gi]) begin
                    inpr_reg[gi] <= bus.dev_in_data[gi*DATA_W +: DATA_W];
                    fgi_reg[gi]  <= 1'b1;
                end else if (bus.cs_inp && hit) begin
                    fgi_reg[gi]  <= 1'b0;
                end
            end

            // CPU write and device handshake are exclusive: they need opposite FGO
            always_ff @(posedge mclk) begin
                if (mrst) begin
                    outr_reg[gi] <= '0;
                    fgo_reg[gi]  <= FGO_RST;
                end else if (bus.cs_out && hit && fgo_reg[gi]) begin
                    outr_reg[gi] <= bus.cs_out_data;
                    fgo_reg[gi]  <= 1'b0;
                end else if (!fgo_reg[gi] && bus.dev_out_ready[gi]) begin
                    fgo_reg[gi]  <= 1'b1;
                end
            end
        end
    endgenerate

    mano_io_arb #(.NCH(NCH), .CH_W(CH_W), .RR(RR)) u_arb (
        .req        (pend),
        .last_grant (last_grant_reg),
        .grant      (grant),
        .any        (any_pend)
    );

    always_ff @(posedge mclk) begin
        if (mrst) begin
            msk_reg     <= '0;
            ien_reg     <= 1'b0;
            out_ovr_reg <= 1'b0;
        end else begin
            if (bus.cs_msk_ld)
                msk_reg <= bus.cs_out_data[NCH-1:0];
            if (bus.cs_r_clr || bus.cs_iof)
                ien_reg <= 1'b0;
            else if (bus.cs_ion)
                ien_reg <= 1'b1;
            out_ovr_reg <= bus.cs_out && sel_ok && !fgo_reg[bus.cs_ch_sel];
        end
    end

    // R flag: grant captured once at the boundary and frozen until the cycle ends
    always_ff @(posedge mclk) begin
        if (mrst) begin
            state_reg      <= ST_IDLE;
            int_vec_reg    <= '0;
            last_grant_reg <= CH_W'(NCH - 1);
        end else if (state_reg == ST_IDLE) begin
            if (bus.cs_t0 && ien_reg && any_pend) begin
                state_reg      <= ST_ACK;
                int_vec_reg    <= grant;
                last_grant_reg <= grant;
            end
        end else if (bus.cs_r_clr) begin
            state_reg <= ST_IDLE;
        end
    end
endmodule

// File: tb/tb_mano_io_intr.sv
// Directed bench for mano_io_intr: one fixed-priority and one round-robin
// instance sharing clock and reset, each scenario in its own task.
module tb_mano_io_intr;
    logic mclk;
    logic mrst;
    int   checks;
    int   errors;

    mano_io_intr_if #(.DATA_W(8), .NCH(4)) bus_fx ();
    mano_io_intr_if #(.DATA_W(8), .NCH(4)) bus_rr ();

    mano_io_intr #(.DATA_W(8), .NCH(4), .CH_W(2), .RR(0)) dut_fx (
        .mclk (mclk), .mrst (mrst), .bus (bus_fx)
    );
    mano_io_intr #(.DATA_W(8), .NCH(4), .CH_W(2), .RR(1)) dut_rr (
        .mclk (mclk), .mrst (mrst), .bus (bus_rr)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_fx.dev_in_valid = '0; bus_fx.dev_in_data = '0; bus_fx.dev_out_ready = '0;
        bus_fx.cs_ch_sel = '0; bus_fx.cs_inp = 0; bus_fx.cs_out = 0; bus_fx.cs_out_data = '0;
        bus_fx.cs_msk_ld = 0; bus_fx.cs_ion = 0; bus_fx.cs_iof = 0; bus_fx.cs_t0 = 0;
        bus_fx.cs_r_clr = 0;
        bus_rr.dev_in_valid = '0; bus_rr.dev_in_data = '0; bus_rr.dev_out_ready = '0;
        bus_rr.cs_ch_sel = '0; bus_rr.cs_inp = 0; bus_rr.cs_out = 0; bus_rr.cs_out_data = '0;
        bus_rr.cs_msk_ld = 0; bus_rr.cs_ion = 0; bus_rr.cs_iof = 0; bus_rr.cs_t0 = 0;
        bus_rr.cs_r_clr = 0;
    endtask

    task automatic do_reset();
        mrst = 1'b1;
        tick();
        mrst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        do_reset();
        checks++;
        if (bus_fx.dev_out_valid !== 4'b0000) begin
            errors++; $display("FAIL reset_out_valid: got %b want 0000", bus_fx.dev_out_valid);
        end
        checks++;
        if (bus_fx.dev_in_ready !== 4'b1111) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1111", bus_fx.dev_in_ready);
        end
        checks++;
        if ({bus_fx.r_flag, bus_fx.ien_flag, bus_fx.out_ovr, bus_fx.int_vec} !== 5'b00000) begin
            errors++; $display("FAIL reset_flags: got r=%b ien=%b ovr=%b vec=%0d want all 0",
                               bus_fx.r_flag, bus_fx.ien_flag, bus_fx.out_ovr, bus_fx.int_vec);
        end
        checks++;
        if (bus_fx.fgo_sel !== 1'b1 || bus_fx.fgi_sel !== 1'b0 || bus_fx.inp_data !== 8'h00) begin
            errors++; $display("FAIL reset_sel: got fgo=%b fgi=%b inp=%h want 1 0 00",
                               bus_fx.fgo_sel, bus_fx.fgi_sel, bus_fx.inp_data);
        end
        $display("txn reset done");
    endtask

    task automatic test_input();
        bus_fx.dev_in_valid = 4'b0100;
        bus_fx.dev_in_data  = 32'h005A_0000;
        tick();
        bus_fx.dev_in_valid = '0;
        bus_fx.dev_in_data  = '0;
        bus_fx.cs_ch_sel    = 2'd2;
        #1;
        checks++;
        if (bus_fx.dev_in_ready !== 4'b1011) begin
            errors++; $display("FAIL in_capture_ready: got %b want 1011", bus_fx.dev_in_ready);
        end
        checks++;
        if (bus_fx.fgi_sel !== 1'b1 || bus_fx.inp_data !== 8'h5A) begin
            errors++; $display("FAIL in_capture_data: got fgi=%b data=%h want 1 5a",
                               bus_fx.fgi_sel, bus_fx.inp_data);
        end
        bus_fx.cs_inp = 1'b1;
        tick();
        bus_fx.cs_inp = 1'b0;
        checks++;
        if (bus_fx.dev_in_ready !== 4'b1111 || bus_fx.fgi_sel !== 1'b0 || bus_fx.inp_data !== 8'h5A) begin
            errors++; $display("FAIL in_consume: got rdy=%b fgi=%b data=%h want 1111 0 5a",
                               bus_fx.dev_in_ready, bus_fx.fgi_sel, bus_fx.inp_data);
        end
        $display("txn input ch2 0x5a captured and consumed");
    endtask

    task automatic test_output();
        bus_fx.cs_ch_sel = 2'd1;
        bus_fx.cs_out = 1'b1;
        bus_fx.cs_out_data = 8'h33;
        tick();
        checks++;
        if (bus_fx.dev_out_valid !== 4'b0010 || bus_fx.dev_out_data[15:8] !== 8'h33 || bus_fx.out_ovr !== 1'b0) begin
            errors++; $display("FAIL out_write: got vld=%b data=%h ovr=%b want 0010 33 0",
                               bus_fx.dev_out_valid, bus_fx.dev_out_data[15:8], bus_fx.out_ovr);
        end
        bus_fx.cs_out_data = 8'h44;
        tick();
        bus_fx.cs_out = 1'b0;
        checks++;
        if (bus_fx.out_ovr !== 1'b1 || bus_fx.dev_out_data[15:8] !== 8'h33) begin
            errors++; $display("FAIL out_overrun: got ovr=%b data=%h want 1 33",
                               bus_fx.out_ovr, bus_fx.dev_out_data[15:8]);
        end
        bus_fx.dev_out_ready = 4'b0010;
        tick();
        bus_fx.dev_out_ready = '0;
        checks++;
        if (bus_fx.out_ovr !== 1'b0 || bus_fx.dev_out_valid !== 4'b0000 || bus_fx.fgo_sel !== 1'b1) begin
            errors++; $display("FAIL out_handshake: got ovr=%b vld=%b fgo=%b want 0 0000 1",
                               bus_fx.out_ovr, bus_fx.dev_out_valid, bus_fx.fgo_sel);
        end
        $display("txn output ch1 0x33 sent, 0x44 dropped");
    endtask

    task automatic test_fixed_irq();
        do_reset();
        bus_fx.cs_msk_ld = 1'b1; bus_fx.cs_out_data = 8'h05; tick(); bus_fx.cs_msk_ld = 1'b0;
        bus_fx.cs_ion = 1'b1; tick(); bus_fx.cs_ion = 1'b0;
        bus_fx.cs_out = 1'b1; bus_fx.cs_ch_sel = 2'd0; tick();
        bus_fx.cs_ch_sel = 2'd2; tick(); bus_fx.cs_out = 1'b0;
        // Masked channels 1/3 still have FGO=1; 0/2 are now idle
        bus_fx.cs_t0 = 1'b1; tick(); bus_fx.cs_t0 = 1'b0;
        checks++;
        if (bus_fx.r_flag !== 1'b0) begin
            errors++; $display("FAIL irq_masked: got r=%b want 0", bus_fx.r_flag);
        end
        bus_fx.dev_in_valid = 4'b0101; tick(); bus_fx.dev_in_valid = '0;
        bus_fx.cs_t0 = 1'b1; tick();
        checks++;
        if (bus_fx.r_flag !== 1'b1 || bus_fx.int_vec !== 2'd0) begin
            errors++; $display("FAIL irq_grant_fixed: got r=%b vec=%0d want 1 0",
                               bus_fx.r_flag, bus_fx.int_vec);
        end
        tick(); bus_fx.cs_t0 = 1'b0;
        bus_fx.cs_r_clr = 1'b1; tick(); bus_fx.cs_r_clr = 1'b0;
        checks++;
        if (bus_fx.r_flag !== 1'b0 || bus_fx.ien_flag !== 1'b0) begin
            errors++; $display("FAIL irq_rclr: got r=%b ien=%b want 0 0", bus_fx.r_flag, bus_fx.ien_flag);
        end
        bus_fx.cs_t0 = 1'b1; tick(); bus_fx.cs_t0 = 1'b0;
        checks++;
        if (bus_fx.r_flag !== 1'b0) begin
            errors++; $display("FAIL irq_ien_off: got r=%b want 0", bus_fx.r_flag);
        end
        bus_fx.cs_ion = 1'b1; tick(); bus_fx.cs_ion = 1'b0;
        bus_fx.cs_t0 = 1'b1; tick(); bus_fx.cs_t0 = 1'b0;
        checks++;
        if (bus_fx.r_flag !== 1'b1 || bus_fx.int_vec !== 2'd0) begin
            errors++; $display("FAIL irq_regrant_fixed: got r=%b vec=%0d want 1 0",
                               bus_fx.r_flag, bus_fx.int_vec);
        end
        bus_fx.cs_r_clr = 1'b1; tick(); bus_fx.cs_r_clr = 1'b0;
        $display("txn fixed-priority interrupt granted ch0 twice");
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_vec [5];
        exp_vec = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        bus_rr.dev_in_valid = 4'b1111; tick(); bus_rr.dev_in_valid = '0;
        bus_rr.cs_msk_ld = 1'b1; bus_rr.cs_out_data = 8'h0F; tick(); bus_rr.cs_msk_ld = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus_rr.cs_ion = 1'b1; tick(); bus_rr.cs_ion = 1'b0;
            bus_rr.cs_t0 = 1'b1; tick(); bus_rr.cs_t0 = 1'b0;
            checks++;
            if (bus_rr.r_flag !== 1'b1 || bus_rr.int_vec !== exp_vec[k]) begin
                errors++; $display("FAIL rr_round%0d: got r=%b vec=%0d want 1 %0d",
                                   k, bus_rr.r_flag, bus_rr.int_vec, exp_vec[k]);
            end
            bus_rr.cs_r_clr = 1'b1; tick(); bus_rr.cs_r_clr = 1'b0;
            $display("txn rr round %0d vec=%0d", k, bus_rr.int_vec);
        end
    endtask

    task automatic test_ien_and_reset();
        bus_fx.cs_ion = 1'b1; tick();
        checks++;
        if (bus_fx.ien_flag !== 1'b1) begin
            errors++; $display("FAIL ien_set: got %b want 1", bus_fx.ien_flag);
        end
        bus_fx.cs_iof = 1'b1; tick();
        bus_fx.cs_ion = 1'b0; bus_fx.cs_iof = 1'b0;
        checks++;
        if (bus_fx.ien_flag !== 1'b0) begin
            errors++; $display("FAIL ien_iof_wins: got %b want 0", bus_fx.ien_flag);
        end
        bus_fx.cs_msk_ld = 1'b1; bus_fx.cs_out_data = 8'h0F; bus_fx.cs_ion = 1'b1; tick();
        bus_fx.cs_msk_ld = 1'b0; bus_fx.cs_ion = 1'b0;
        bus_fx.cs_out = 1'b1; bus_fx.cs_ch_sel = 2'd3; bus_fx.cs_out_data = 8'hA5; tick();
        bus_fx.cs_out = 1'b0;
        bus_fx.cs_t0 = 1'b1; tick(); bus_fx.cs_t0 = 1'b0;
        checks++;
        if (bus_fx.r_flag !== 1'b1 || bus_fx.dev_out_valid !== 4'b1000) begin
            errors++; $display("FAIL pre_reset_ack: got r=%b vld=%b want 1 1000",
                               bus_fx.r_flag, bus_fx.dev_out_valid);
        end
        do_reset();
        checks++;
        if (bus_fx.r_flag !== 1'b0 || bus_fx.dev_out_valid !== 4'b0000 || bus_fx.dev_out_data !== 32'h0) begin
            errors++; $display("FAIL reset_in_ack: got r=%b vld=%b data=%h want 0 0000 0",
                               bus_fx.r_flag, bus_fx.dev_out_valid, bus_fx.dev_out_data);
        end
        // Mask cleared by reset: FGO=1 everywhere must no longer interrupt
        bus_fx.cs_ion = 1'b1; tick(); bus_fx.cs_ion = 1'b0;
        bus_fx.cs_t0 = 1'b1; tick(); bus_fx.cs_t0 = 1'b0;
        checks++;
        if (bus_fx.r_flag !== 1'b0 || bus_fx.ien_flag !== 1'b1) begin
            errors++; $display("FAIL reset_mask_cleared: got r=%b ien=%b want 0 1",
                               bus_fx.r_flag, bus_fx.ien_flag);
        end
        $display("txn ien priority and reset during ack");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mrst = 1'b1;
        idle_inputs();
        test_reset();
        test_input();
        test_output();
        test_fixed_irq();
        test_round_robin();
        test_ien_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
